// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets and STATUS bit positions.
package dmem_pkg;

  localparam logic [4:0] OFS_GPIO   = 5'h00;
  localparam logic [4:0] OFS_COUNT  = 5'h04;
  localparam logic [4:0] OFS_CMP    = 5'h08;
  localparam logic [4:0] OFS_STATUS = 5'h0C;
  localparam logic [4:0] OFS_TXDATA = 5'h10;

  localparam int ST_MATCH = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

endpackage

// File: rtl/dmem_tx_fifo.sv
// Byte TX FIFO with valid/ready drain; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module dmem_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       full,
  output logic       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          empty;
  logic          pop;
  logic          accept;

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == FULL_CNT);
  assign valid  = !empty;
  assign data   = empty ? 8'h00 : mem[rd_ptr_reg];
  assign pop    = valid && ready;
  assign accept = push && (!full || pop);
  assign drop   = push && !accept;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_reg] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (accept && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !accept) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for the single-cycle MIPS core: word RAM plus GPIO, timer and TX FIFO MMIO page.
// Define MMIO_TIMER_EN to build the COUNT/CMP timer and STATUS.match interrupt.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] gpio_out,
  output logic        timer_irq,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int          RAW       = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0]    ram [RAM_WORDS];
  logic [RAW-1:0] ram_idx;
  logic           ram_hit;
  logic           mmio_hit;
  logic [4:0]     mmio_ofs;
  logic           wr_gpio;
  logic           wr_status;
  logic           wr_tx;

  logic [31:0] gpio_reg;
  logic        overflow_reg;
  logic        fifo_full;
  logic        fifo_drop;
  logic [31:0] count_val;
  logic [31:0] cmp_val;
  logic        match;

  assign ram_hit   = (addr < RAM_BYTES);
  assign ram_idx   = addr[RAW+1:2];
  assign mmio_hit  = (addr[31:5] == MMIO_BASE[31:5]);
  assign mmio_ofs  = {addr[4:2], 2'b00};
  assign wr_gpio   = memwrite && mmio_hit && (mmio_ofs == OFS_GPIO);
  assign wr_status = memwrite && mmio_hit && (mmio_ofs == OFS_STATUS);
  assign wr_tx     = memwrite && mmio_hit && (mmio_ofs == OFS_TXDATA);

  always_ff @(posedge clk) begin
    if (memwrite && ram_hit) ram[ram_idx] <= writedata;
  end

  // Sticky overflow: a new drop in the same cycle as a W1C wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_gpio) gpio_reg <= writedata;
      if (fifo_drop)                          overflow_reg <= 1'b1;
      else if (wr_status && writedata[ST_OVF]) overflow_reg <= 1'b0;
    end
  end

`ifdef MMIO_TIMER_EN
  logic        wr_cmp;
  logic [31:0] count_reg;
  logic [31:0] cmp_reg;
  logic        match_reg;

  assign wr_cmp = memwrite && mmio_hit && (mmio_ofs == OFS_CMP);

  // The compare always uses the registered CMP, so a CMP write is seen one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      cmp_reg   <= 32'hFFFF_FFFF;
      match_reg <= 1'b0;
    end else begin
      count_reg <= count_reg + 32'd1;
      if (wr_cmp) cmp_reg <= writedata;
      if (count_reg == cmp_reg)                  match_reg <= 1'b1;
      else if (wr_status && writedata[ST_MATCH]) match_reg <= 1'b0;
    end
  end

  assign count_val = count_reg;
  assign cmp_val   = cmp_reg;
  assign match     = match_reg;
`else
  assign count_val = '0;
  assign cmp_val   = '0;
  assign match     = 1'b0;
`endif

  dmem_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_tx),
    .push_data (writedata[7:0]),
    .ready     (tx_ready),
    .valid     (tx_valid),
    .data      (tx_data),
    .full      (fifo_full),
    .drop      (fifo_drop)
  );

  always_comb begin
    readdata = '0;
    if (ram_hit) begin
      readdata = ram[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_ofs)
        OFS_GPIO:   readdata = gpio_reg;
        OFS_COUNT:  readdata = count_val;
        OFS_CMP:    readdata = cmp_val;
        OFS_STATUS: readdata = {29'd0, overflow_reg, fifo_full, match};
        default:    readdata = '0;
      endcase
    end
  end

  assign gpio_out  = gpio_reg;
  assign timer_irq = match;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: RAM, GPIO, async reset, TX FIFO and (when built) the timer.
module tb_dmem_responder;

  localparam logic [31:0] A_GPIO   = 32'hFFFF_0000;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_0004;
  localparam logic [31:0] A_CMP    = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;
  localparam logic [31:0] A_TX     = 32'hFFFF_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] gpio_out;
  logic        timer_irq;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    writedata = d;
    memwrite = 1'b1;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    memwrite = 1'b0;
    addr = a;
    #1;
    d = readdata;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check_eq("rst_gpio", gpio_out, 32'h0);
    check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
    check_eq("rst_tx_data", {24'd0, tx_data}, 32'h0);
    check_eq("rst_irq", {31'd0, timer_irq}, 32'h0);
    bus_read(A_STATUS, rd);
    check_eq("rst_status", rd, 32'h0);
    #8 reset = 1'b1;
    step();

`ifdef MMIO_TIMER_EN
    bus_write(A_CMP, 32'd20);
    for (int i = 0; i < 40 && !timer_irq; i++) step();
    check_eq("irq_after_cmp20", {31'd0, timer_irq}, 32'h1);
    bus_read(A_STATUS, rd);
    check_eq("status_match", rd, 32'h1);
    bus_write(A_STATUS, 32'h1);
    check_eq("irq_w1c", {31'd0, timer_irq}, 32'h0);
    // Arrange for the W1C to land on the very edge where COUNT==CMP.
    bus_read(A_COUNT, rd);
    bus_write(A_CMP, rd + 32'd5);
    repeat (4) step();
    bus_write(A_STATUS, 32'h1);
    check_eq("irq_set_wins", {31'd0, timer_irq}, 32'h1);
    bus_write(A_STATUS, 32'h1);
    check_eq("irq_cleared", {31'd0, timer_irq}, 32'h0);
`else
    repeat (100) step();
    bus_read(A_COUNT, rd);
    check_eq("count_disabled", rd, 32'h0);
    check_eq("irq_disabled", {31'd0, timer_irq}, 32'h0);
`endif

    bus_write(32'h14, 32'h1111_1111);
    bus_write(32'h10, 32'hDEAD_BEEF);
    bus_read(32'h10, rd);
    check_eq("ram_0x10", rd, 32'hDEAD_BEEF);
    bus_read(32'h13, rd);
    check_eq("ram_0x13", rd, 32'hDEAD_BEEF);
    bus_read(32'h14, rd);
    check_eq("ram_0x14", rd, 32'h1111_1111);
    bus_read(32'h0000_1000, rd);
    check_eq("unmapped", rd, 32'h0);
    bus_read(A_TX, rd);
    check_eq("txdata_read", rd, 32'h0);

    bus_write(A_GPIO, 32'h5A5A_0001);
    check_eq("gpio_out", gpio_out, 32'h5A5A_0001);
    bus_read(A_GPIO, rd);
    check_eq("gpio_read", rd, 32'h5A5A_0001);

    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(A_TX, 32'h41 + 32'(i));
    bus_read(A_STATUS, rd);
    check_eq("status_full_ovf", rd, 32'h6);
    check_eq("tx_valid_full", {31'd0, tx_valid}, 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_byte", {24'd0, tx_data}, 32'h41 + 32'(i));
      step();
    end
    check_eq("drain_done", {31'd0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    bus_write(A_STATUS, 32'h4);
    bus_read(A_STATUS, rd);
    check_eq("ovf_cleared", rd, 32'h0);

    for (int i = 0; i < 4; i++) bus_write(A_TX, 32'h50 + 32'(i));
    tx_ready = 1'b1;
    bus_write(A_TX, 32'h46);
    tx_ready = 1'b0;
    bus_read(A_STATUS, rd);
    check_eq("push_pop_full", rd, 32'h2);
    check_eq("head_after_pp", {24'd0, tx_data}, 32'h51);
    tx_ready = 1'b1;
    step();
    step();
    step();
    check_eq("last_byte", {24'd0, tx_data}, 32'h46);
    step();
    check_eq("pp_drained", {31'd0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    bus_write(A_GPIO, 32'h0000_00FF);
    bus_write(A_TX, 32'h77);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_gpio", gpio_out, 32'h0);
    check_eq("async_rst_txv", {31'd0, tx_valid}, 32'h0);
    #2 reset = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
